regfile_sb: RTL and testbench

- Parametrised integer register file with N combinational read ports, one write-back port and a per-register busy scoreboard for pipelined hazard detection.
- Writes commit on the rising edge and are forwarded write-through to same-cycle reads.
- Sits between decode (read/issue) and write-back; RV32I (NREGS=32) and RV32E (NREGS=16) builds share one module.

---
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with combinational read ports, one write-back port
// and a per-register busy scoreboard for decode-stage hazard detection.
module regfile_sb #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NREGS   = 32,
    parameter int unsigned     NREAD   = 2,
    parameter int unsigned     SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h7cc)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*5-1:0]    rd_name,
    output logic [NREAD*XLEN-1:0] rd_val,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wb_en,
    input  logic [4:0]            wb_name,
    input  logic [XLEN-1:0]       wb_val,
    input  logic                  iss_en,
    input  logic [4:0]            iss_name,
    input  logic                  flush,
    output logic                  busy_any
);

    localparam int unsigned IDX_W = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic             wb_ok;
    logic             iss_ok;
    logic [IDX_W-1:0] wb_idx;
    logic [IDX_W-1:0] iss_idx;

    // x0 and names beyond the implemented file are never stored or tracked.
    function automatic logic name_ok(input logic [4:0] n);
        return (32'(n) < NREGS) && (n != 5'd0);
    endfunction

    assign wb_ok   = wb_en && name_ok(wb_name);
    assign iss_ok  = iss_en && name_ok(iss_name);
    assign wb_idx  = wb_name[IDX_W-1:0];
    assign iss_idx = iss_name[IDX_W-1:0];

    // Read ports: write-through bypass, and a landing write-back clears the hazard.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [4:0]       name;
        logic [IDX_W-1:0] idx;
        logic             valid;
        logic             hit;

        assign name  = rd_name[5*k +: 5];
        assign idx   = name[IDX_W-1:0];
        assign valid = name_ok(name);
        assign hit   = wb_ok && (wb_name == name);

        assign rd_val[XLEN*k +: XLEN] = !valid ? '0 :
                                        hit    ? wb_val : regs_q[idx];
        assign rd_busy[k] = valid && busy_q[idx] && !hit;
    end

    assign busy_any = |busy_q;

    // Next state; later assignments win, so issue overrides flush and write-back.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_ok) begin
            regs_d[wb_idx] = wb_val;
            busy_d[wb_idx] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (iss_ok) begin
            busy_d[iss_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX && i != 0) ? SP_INIT : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default RV32I build and an RV32E build
// with three read ports.
module tb_regfile_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // RV32I build, 2 read ports
    logic        rst;
    logic [9:0]  rd_name;
    logic [63:0] rd_val;
    logic [1:0]  rd_busy;
    logic        wb_en;
    logic [4:0]  wb_name;
    logic [31:0] wb_val;
    logic        iss_en;
    logic [4:0]  iss_name;
    logic        flush;
    logic        busy_any;

    // RV32E build, 3 read ports
    logic        e_rst;
    logic [14:0] e_rd_name;
    logic [95:0] e_rd_val;
    logic [2:0]  e_rd_busy;
    logic        e_wb_en;
    logic [4:0]  e_wb_name;
    logic [31:0] e_wb_val;
    logic        e_iss_en;
    logic [4:0]  e_iss_name;
    logic        e_flush;
    logic        e_busy_any;

    int n_pass  = 0;
    int n_total = 0;

    regfile_sb u_dut (
        .clk(clk), .rst(rst), .rd_name(rd_name), .rd_val(rd_val), .rd_busy(rd_busy),
        .wb_en(wb_en), .wb_name(wb_name), .wb_val(wb_val),
        .iss_en(iss_en), .iss_name(iss_name), .flush(flush), .busy_any(busy_any)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .NREAD(3), .SP_IDX(2), .SP_INIT(32'h7cc)) u_e (
        .clk(clk), .rst(e_rst), .rd_name(e_rd_name), .rd_val(e_rd_val), .rd_busy(e_rd_busy),
        .wb_en(e_wb_en), .wb_name(e_wb_name), .wb_val(e_wb_val),
        .iss_en(e_iss_en), .iss_name(e_iss_name), .flush(e_flush), .busy_any(e_busy_any)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wb_en = 0; wb_name = 0; wb_val = 0; iss_en = 0; iss_name = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        rd_name = 0;
        rst = 1;
        step();
        rst = 0;
        rd_name = {5'd2, 5'd0};
        #1;
        n_total++;
        if (rd_val[31:0] !== 32'h0) $display("FAIL reset_x0: got %h expected %h", rd_val[31:0], 32'h0);
        else n_pass++;
        n_total++;
        if (rd_val[63:32] !== 32'h7cc) $display("FAIL reset_sp: got %h expected %h", rd_val[63:32], 32'h7cc);
        else n_pass++;
        rd_name = {5'd2, 5'd5};
        #1;
        n_total++;
        if (rd_val[31:0] !== 32'h0) $display("FAIL reset_x5: got %h expected %h", rd_val[31:0], 32'h0);
        else n_pass++;
        n_total++;
        if (rd_busy !== 2'b00) $display("FAIL reset_rd_busy: got %b expected %b", rd_busy, 2'b00);
        else n_pass++;
        n_total++;
        if (busy_any !== 1'b0) $display("FAIL reset_busy_any: got %b expected %b", busy_any, 1'b0);
        else n_pass++;
    endtask

    task automatic test_write_bypass();
        idle();
        wb_en = 1; wb_name = 5'd5; wb_val = 32'hdeadbeef;
        rd_name = {5'd0, 5'd5};
        #1;
        n_total++;
        if (rd_val[31:0] !== 32'hdeadbeef) $display("FAIL bypass_same_cycle: got %h expected %h", rd_val[31:0], 32'hdeadbeef);
        else n_pass++;
        step();
        wb_en = 0;
        #1;
        n_total++;
        if (rd_val[31:0] !== 32'hdeadbeef) $display("FAIL write_stored: got %h expected %h", rd_val[31:0], 32'hdeadbeef);
        else n_pass++;
    endtask

    task automatic test_x0();
        idle();
        wb_en = 1; wb_name = 5'd0; wb_val = 32'h1234;
        rd_name = {5'd5, 5'd0};
        #1;
        n_total++;
        if (rd_val[31:0] !== 32'h0) $display("FAIL x0_bypass: got %h expected %h", rd_val[31:0], 32'h0);
        else n_pass++;
        step();
        wb_en = 0;
        #1;
        n_total++;
        if (rd_val[31:0] !== 32'h0) $display("FAIL x0_stored: got %h expected %h", rd_val[31:0], 32'h0);
        else n_pass++;
        iss_en = 1; iss_name = 5'd0;
        step();
        iss_en = 0;
        #1;
        n_total++;
        if (busy_any !== 1'b0) $display("FAIL x0_issue: got %b expected %b", busy_any, 1'b0);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en = 1; iss_name = 5'd7;
        rd_name = {5'd7, 5'd7};
        #1;
        n_total++;
        if (rd_busy !== 2'b00) $display("FAIL issue_not_same_cycle: got %b expected %b", rd_busy, 2'b00);
        else n_pass++;
        step();
        iss_en = 0;
        #1;
        n_total++;
        if (rd_busy !== 2'b11) $display("FAIL issue_busy: got %b expected %b", rd_busy, 2'b11);
        else n_pass++;
        n_total++;
        if (busy_any !== 1'b1) $display("FAIL issue_busy_any: got %b expected %b", busy_any, 1'b1);
        else n_pass++;
        wb_en = 1; wb_name = 5'd7; wb_val = 32'h55;
        #1;
        n_total++;
        if (rd_busy !== 2'b00) $display("FAIL wb_resolves: got %b expected %b", rd_busy, 2'b00);
        else n_pass++;
        n_total++;
        if (rd_val !== {32'h55, 32'h55}) $display("FAIL wb_bypass_both: got %h expected %h", rd_val, {32'h55, 32'h55});
        else n_pass++;
        n_total++;
        if (busy_any !== 1'b1) $display("FAIL busy_any_no_bypass: got %b expected %b", busy_any, 1'b1);
        else n_pass++;
        step();
        wb_en = 0;
        #1;
        n_total++;
        if (busy_any !== 1'b0) $display("FAIL wb_clears: got %b expected %b", busy_any, 1'b0);
        else n_pass++;
        n_total++;
        if (rd_val[31:0] !== 32'h55) $display("FAIL wb_stored: got %h expected %h", rd_val[31:0], 32'h55);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        idle();
        iss_en = 1; iss_name = 5'd9;
        wb_en = 1; wb_name = 5'd9; wb_val = 32'h99;
        flush = 1;
        step();
        idle();
        rd_name = {5'd0, 5'd9};
        #1;
        n_total++;
        if (rd_busy[0] !== 1'b1) $display("FAIL issue_beats_all: got %b expected %b", rd_busy[0], 1'b1);
        else n_pass++;
        n_total++;
        if (rd_val[31:0] !== 32'h99) $display("FAIL simul_data: got %h expected %h", rd_val[31:0], 32'h99);
        else n_pass++;
        // retire x9, then load x3 and mark it busy
        wb_en = 1; wb_name = 5'd9; wb_val = 32'h99;
        step();
        wb_name = 5'd3; wb_val = 32'h33;
        step();
        idle();
        iss_en = 1; iss_name = 5'd3;
        step();
        idle();
        rd_name = {5'd0, 5'd3};
        #1;
        n_total++;
        if (rd_busy[0] !== 1'b1) $display("FAIL x3_busy: got %b expected %b", rd_busy[0], 1'b1);
        else n_pass++;
        flush = 1;
        step();
        flush = 0;
        #1;
        n_total++;
        if (busy_any !== 1'b0) $display("FAIL flush_clears: got %b expected %b", busy_any, 1'b0);
        else n_pass++;
        n_total++;
        if (rd_val[31:0] !== 32'h33) $display("FAIL flush_keeps_data: got %h expected %h", rd_val[31:0], 32'h33);
        else n_pass++;
    endtask

    task automatic test_wb_not_busy();
        idle();
        wb_en = 1; wb_name = 5'd6; wb_val = 32'h6666;
        step();
        idle();
        rd_name = {5'd6, 5'd3};
        #1;
        n_total++;
        if (busy_any !== 1'b0) $display("FAIL wb_idle_busy: got %b expected %b", busy_any, 1'b0);
        else n_pass++;
        n_total++;
        if (rd_val !== {32'h6666, 32'h33}) $display("FAIL wb_idle_data: got %h expected %h", rd_val, {32'h6666, 32'h33});
        else n_pass++;
    endtask

    task automatic test_rv32e();
        e_rst = 1; e_wb_en = 0; e_wb_name = 0; e_wb_val = 0; e_iss_en = 0; e_iss_name = 0; e_flush = 0;
        e_rd_name = {5'd2, 5'd2, 5'd2};
        step();
        e_rst = 0;
        #1;
        n_total++;
        if (e_rd_val !== {32'h7cc, 32'h7cc, 32'h7cc}) $display("FAIL e_sp_three_ports: got %h expected %h", e_rd_val, {32'h7cc, 32'h7cc, 32'h7cc});
        else n_pass++;
        e_wb_en = 1; e_wb_name = 5'd20; e_wb_val = 32'habcd;
        e_rd_name = {5'd4, 5'd2, 5'd20};
        #1;
        n_total++;
        if (e_rd_val[31:0] !== 32'h0) $display("FAIL e_oor_bypass: got %h expected %h", e_rd_val[31:0], 32'h0);
        else n_pass++;
        step();
        e_wb_en = 0;
        #1;
        n_total++;
        if (e_rd_val !== {32'h0, 32'h7cc, 32'h0}) $display("FAIL e_oor_ignored: got %h expected %h", e_rd_val, {32'h0, 32'h7cc, 32'h0});
        else n_pass++;
        e_iss_en = 1; e_iss_name = 5'd20;
        step();
        e_iss_en = 0;
        #1;
        n_total++;
        if (e_busy_any !== 1'b0) $display("FAIL e_oor_issue: got %b expected %b", e_busy_any, 1'b0);
        else n_pass++;
        e_wb_en = 1; e_wb_name = 5'd4; e_wb_val = 32'h77;
        step();
        e_wb_en = 0;
        e_iss_en = 1; e_iss_name = 5'd4;
        step();
        e_iss_en = 0;
        #1;
        n_total++;
        if (e_rd_busy !== 3'b100 || e_busy_any !== 1'b1) $display("FAIL e_x4_busy: got %b/%b expected %b/%b", e_rd_busy, e_busy_any, 3'b100, 1'b1);
        else n_pass++;
        n_total++;
        if (e_rd_val[95:64] !== 32'h77) $display("FAIL e_x4_data: got %h expected %h", e_rd_val[95:64], 32'h77);
        else n_pass++;
        // reset wins over a same-cycle write and issue
        e_rst = 1; e_wb_en = 1; e_wb_name = 5'd4; e_wb_val = 32'h88; e_iss_en = 1; e_iss_name = 5'd5;
        step();
        e_rst = 0; e_wb_en = 0; e_iss_en = 0;
        #1;
        n_total++;
        if (e_busy_any !== 1'b0 || e_rd_busy !== 3'b000) $display("FAIL e_reset_busy: got %b/%b expected %b/%b", e_busy_any, e_rd_busy, 1'b0, 3'b000);
        else n_pass++;
        n_total++;
        if (e_rd_val[95:64] !== 32'h0) $display("FAIL e_reset_x4: got %h expected %h", e_rd_val[95:64], 32'h0);
        else n_pass++;
    endtask

    initial begin
        idle();
        rd_name = 0;
        e_rst = 0; e_rd_name = 0; e_wb_en = 0; e_wb_name = 0; e_wb_val = 0;
        e_iss_en = 0; e_iss_name = 0; e_flush = 0;
        #1;
        test_reset();
        test_write_bypass();
        test_x0();
        test_scoreboard();
        test_simultaneous();
        test_wb_not_busy();
        test_rv32e();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
